// File: rtl/seg7_result_display.sv
// Signed result display: double-dabble binary-to-BCD conversion feeding a
// scanned 6-digit common-anode seven-segment display (sign + 5 digits).
module seg7_result_display #(
    parameter int N_DIGITS = 6,
    parameter int VAL_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scan_clk,
    input  logic [VAL_W-1:0]    value_in,
    input  logic                load,
    output logic                busy,
    output logic                done,
    output logic [N_DIGITS-1:0] an,
    output logic [6:0]          seg,
    output logic                dp
);

    localparam int BCD_W = 20;
    localparam int CNT_W = $clog2(VAL_W);
    localparam int IDX_W = $clog2(N_DIGITS);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state_reg, state_next;
    logic                sign_reg;
    logic [VAL_W-1:0]    mag_reg;
    logic [BCD_W-1:0]    bcd_reg;
    logic [BCD_W-1:0]    bcd_adj;
    logic [CNT_W-1:0]    cnt_reg;
    logic [BCD_W-1:0]    disp_bcd_reg;
    logic                disp_sign_reg;
    logic                done_reg;
    logic [2:0]          sync_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [N_DIGITS-1:0] an_reg, an_next;
    logic [6:0]          seg_reg, seg_next;
    logic [4:0]          digit_blank;
    logic [6:0]          seg_by_idx [0:(1<<IDX_W)-1];
    logic                show_minus;
    logic                scan_rise;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction on every nibble >= 5 before each shift
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (cnt_reg == CNT_W'(VAL_W - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sign_reg      <= 1'b0;
            mag_reg       <= '0;
            bcd_reg       <= '0;
            cnt_reg       <= '0;
            disp_bcd_reg  <= '0;
            disp_sign_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == COMMIT);
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        sign_reg <= value_in[VAL_W-1];
                        mag_reg  <= value_in[VAL_W-1] ? (~value_in + VAL_W'(1)) : value_in;
                        bcd_reg  <= '0;
                        cnt_reg  <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_reg, mag_reg} <= {bcd_adj, mag_reg} << 1;
                    cnt_reg            <= cnt_reg + CNT_W'(1);
                end
                COMMIT: begin
                    disp_bcd_reg  <= bcd_reg;
                    disp_sign_reg <= sign_reg;
                end
                default: ;
            endcase
        end
    end

    // A digit is blank when it and every digit above it are zero; digit0 always shows
    assign show_minus = disp_sign_reg & (|disp_bcd_reg);

    generate
        for (gi = 0; gi < 5; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign digit_blank[gi] = 1'b0;
            end else begin : g_upper
                assign digit_blank[gi] = ~(|disp_bcd_reg[BCD_W-1:gi*4]);
            end
        end
        for (gi = 0; gi < (1 << IDX_W); gi++) begin : g_segmux
            if (gi < 5) begin : g_digit
                assign seg_by_idx[gi] = digit_blank[gi] ? 7'b1111111 :
                                        seg_encode(disp_bcd_reg[gi*4 +: 4]);
            end else if (gi == 5) begin : g_sign
                assign seg_by_idx[gi] = show_minus ? 7'b0111111 : 7'b1111111;
            end else begin : g_unused
                assign seg_by_idx[gi] = 7'b1111111;
            end
        end
    endgenerate

    // scan_clk is sampled as data: two-flop synchroniser plus one flop for edge detect
    assign scan_rise = sync_reg[1] & ~sync_reg[2];
    assign an_next   = ~(N_DIGITS'(1) << idx_reg);
    assign seg_next  = seg_by_idx[idx_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            idx_reg  <= '0;
            an_reg   <= '1;
            seg_reg  <= 7'b1111111;
        end else begin
            sync_reg <= {sync_reg[1:0], scan_clk};
            if (scan_rise) begin
                idx_reg <= (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign an   = an_reg;
    assign seg  = seg_reg;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_seg7_result_display.sv
// Scoreboard bench: loads push expected digit patterns; a monitor checks done
// timing and every newly scanned digit against a decimal reference model.
module tb_seg7_result_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_clk = 1'b0;
    logic [15:0] value_in = '0;
    logic        load = 1'b0;
    logic        busy, done, dp;
    logic [5:0]  an;
    logic [6:0]  seg;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [41:0] segs;
        int          exp_cyc;
        logic [15:0] v;
    } exp_t;
    exp_t q[$];

    seg7_result_display #(.N_DIGITS(6), .VAL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .scan_clk(scan_clk), .value_in(value_in),
        .load(load), .busy(busy), .done(done), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            repeat ($urandom_range(2, 5)) @(posedge clk);
            #2 scan_clk = ~scan_clk;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: enc = 7'b1000000; 1: enc = 7'b1111001; 2: enc = 7'b0100100;
            3: enc = 7'b0110000; 4: enc = 7'b0011001; 5: enc = 7'b0010010;
            6: enc = 7'b0000010; 7: enc = 7'b1111000; 8: enc = 7'b0000000;
            default: enc = 7'b0010000;
        endcase
    endfunction

    // Expected pattern per digit position, from the decimal value directly
    function automatic logic [41:0] model(input logic [15:0] v);
        int sv, mag, p;
        logic [41:0] s;
        sv  = $signed(v);
        mag = (sv < 0) ? -sv : sv;
        p   = 1;
        for (int i = 0; i < 5; i++) begin
            s[i*7 +: 7] = (i > 0 && mag < p) ? 7'b1111111 : enc((mag / p) % 10);
            p = p * 10;
        end
        s[35 +: 7] = (sv < 0 && mag != 0) ? 7'b0111111 : 7'b1111111;
        return s;
    endfunction

    // Monitor: checks each newly selected digit, then consumes done events
    logic [41:0] cur;
    logic [5:0]  prev_an = 6'h3F;
    int          prev_idx = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            cur = model(16'd0);
            prev_an = an;
        end else begin
            if (an !== prev_an) begin
                int idx;
                idx = -1;
                for (int i = 0; i < 6; i++) if (an == ~(6'd1 << i)) idx = i;
                chk("an_onehot", (idx >= 0), 1);
                if (idx >= 0) begin
                    chk("an_sequence", idx, (prev_an == 6'h3F) ? 0 : (prev_idx + 1) % 6);
                    chk($sformatf("seg_digit%0d", idx), seg, cur[idx*7 +: 7]);
                    chk("dp_off", dp, 1);
                    prev_idx = idx;
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("done_cycle_%0h", e.v), cyc, e.exp_cyc);
                    chk("busy_at_done", busy, 0);
                    cur = e.segs;
                end
            end else if (q.size() > 0 && cyc > q[0].exp_cyc) begin
                chk($sformatf("done_timeout_%0h", q[0].v), 0, 1);
                void'(q.pop_front());
            end
            prev_an = an;
        end
    end

    task automatic issue(input logic [15:0] v);
        exp_t e;
        e.segs = model(v);
        e.exp_cyc = cyc + 1 + 17;
        e.v = v;
        load = 1'b1;
        value_in = v;
        q.push_back(e);
        @(negedge clk);
        load = 1'b0;
        value_in = 16'($urandom);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_conv(input logic [15:0] v);
        int n;
        issue(v);
        wait_idle(n);
        chk($sformatf("busy_cycles_%0h", v), n, 17);
        repeat (130) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_an", an, 6'h3F);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        rst_n = 1'b1;
        repeat (130) @(negedge clk);

        do_conv(16'd1234);
        do_conv(16'hC000);
        do_conv(16'h8000);
        do_conv(16'd7);

        // Load during conversion must be ignored; load right after done accepted
        issue(16'd42);
        repeat (4) @(negedge clk);
        load = 1'b1;
        value_in = 16'd999;
        @(negedge clk);
        load = 1'b0;
        wait_idle(n);
        chk("busy_cycles_ignored", n + 5, 17);
        do_conv(16'($urandom));

        // Async reset in the middle of a conversion
        issue(16'd5555);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_an", an, 6'h3F);
        chk("midrst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (130) @(negedge clk);
        do_conv(16'd31415);

        do_conv(16'd0);
        do_conv(16'hFFFF);
        do_conv(16'h7FFF);
        for (int i = 0; i < 8; i++) do_conv(16'($urandom));

        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
